id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-style decode stage with register file, RAW hazard stall and a
// one-entry valid/ready output register. Optional macro: ID_STAGE_WB_BYPASS_EN.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_en_in,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              mem_wb_en,
    input  logic [REG_W-1:0]  exe_dest,
    input  logic [REG_W-1:0]  mem_dest,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic              imm,
    output logic              two_src,
    output logic [3:0]        exe_cmd,
    output logic [REG_W-1:0]  dest,
    output logic [REG_W-1:0]  src1,
    output logic [REG_W-1:0]  src2,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [DATA_W-1:0] pc_out
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // the sender holds its payload stable until then. A flush makes in_ready high
    // so the upstream beat is consumed and dropped.

    localparam int NREGS = 2 ** REG_W;

    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        cond;
    logic [1:0]        mode;
    logic              imm_bit;
    logic [3:0]        opcode;
    logic              s_in;
    logic              store;
    logic [REG_W-1:0]  d_dest;
    logic [REG_W-1:0]  d_src1;
    logic [REG_W-1:0]  d_src2;
    logic              d_two_src;
    logic [3:0]        d_exe_cmd;
    logic              d_wb_en;
    logic              d_mem_r_en;
    logic              d_mem_w_en;
    logic              d_b;
    logic              d_s;
    logic              cond_ok;
    logic              n_flag;
    logic              z_flag;
    logic              c_flag;
    logic              v_flag;
    logic              src1_busy;
    logic              src2_busy;
    logic              hazard;
    logic              out_free;
    logic [DATA_W-1:0] rn_value;
    logic [DATA_W-1:0] rm_value;

    function automatic logic [REG_W-1:0] reg_idx(input logic [3:0] field);
        return REG_W'(field);
    endfunction

    // Field extraction
    assign cond    = instruction[31:28];
    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_in    = instruction[20];

    assign store     = (mode == 2'b01) && !s_in;
    assign d_src1    = reg_idx(instruction[19:16]);
    assign d_dest    = reg_idx(instruction[15:12]);
    assign d_src2    = store ? d_dest : reg_idx(instruction[3:0]);
    assign d_two_src = !imm_bit || store;

    always_comb begin
        d_exe_cmd  = 4'b0000;
        d_wb_en    = 1'b0;
        d_mem_r_en = 1'b0;
        d_mem_w_en = 1'b0;
        d_b        = 1'b0;
        d_s        = 1'b0;
        case (mode)
            2'b00: begin
                d_wb_en = 1'b1;
                d_s     = s_in;
                case (opcode)
                    4'b1101: d_exe_cmd = 4'b0001;
                    4'b1111: d_exe_cmd = 4'b1001;
                    4'b0100: d_exe_cmd = 4'b0010;
                    4'b0101: d_exe_cmd = 4'b0011;
                    4'b0010: d_exe_cmd = 4'b0100;
                    4'b0110: d_exe_cmd = 4'b0101;
                    4'b0000: d_exe_cmd = 4'b0110;
                    4'b1100: d_exe_cmd = 4'b0111;
                    4'b0001: d_exe_cmd = 4'b1000;
                    4'b1010: begin
                        d_exe_cmd = 4'b0100;
                        d_wb_en   = 1'b0;
                    end
                    4'b1000: begin
                        d_exe_cmd = 4'b0110;
                        d_wb_en   = 1'b0;
                    end
                    default: begin
                        // Unknown ALU opcode retires with no side effects
                        d_wb_en = 1'b0;
                        d_s     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                d_exe_cmd  = 4'b0010;
                d_mem_r_en = s_in;
                d_wb_en    = s_in;
                d_mem_w_en = !s_in;
            end
            2'b10: d_b = 1'b1;
            default: ;
        endcase
    end

    assign n_flag = sr[3];
    assign z_flag = sr[2];
    assign c_flag = sr[1];
    assign v_flag = sr[0];

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z_flag;
            4'b0001: cond_ok = !z_flag;
            4'b0010: cond_ok = c_flag;
            4'b0011: cond_ok = !c_flag;
            4'b0100: cond_ok = n_flag;
            4'b0101: cond_ok = !n_flag;
            4'b0110: cond_ok = v_flag;
            4'b0111: cond_ok = !v_flag;
            4'b1000: cond_ok = c_flag && !z_flag;
            4'b1001: cond_ok = !c_flag || z_flag;
            4'b1010: cond_ok = (n_flag == v_flag);
            4'b1011: cond_ok = (n_flag != v_flag);
            4'b1100: cond_ok = !z_flag && (n_flag == v_flag);
            4'b1101: cond_ok = z_flag || (n_flag != v_flag);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Branches read no registers, so they never wait on in-flight writers
    assign src1_busy = (exe_wb_en && (exe_dest == d_src1)) || (mem_wb_en && (mem_dest == d_src1));
    assign src2_busy = (exe_wb_en && (exe_dest == d_src2)) || (mem_wb_en && (mem_dest == d_src2));
    assign hazard    = in_valid && (mode != 2'b10) && (src1_busy || (d_two_src && src2_busy));
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst && (flush || (!hazard && out_free));

`ifdef ID_STAGE_WB_BYPASS_EN
    assign rn_value = (wb_en_in && (wb_dest == d_src1)) ? wb_value : regs[d_src1];
    assign rm_value = (wb_en_in && (wb_dest == d_src2)) ? wb_value : regs[d_src2];
`else
    assign rn_value = regs[d_src1];
    assign rm_value = regs[d_src2];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in) begin
            regs[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            imm           <= 1'b0;
            two_src       <= 1'b0;
            exe_cmd       <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            pc_out        <= '0;
        end else if (flush || (out_free && (hazard || !in_valid))) begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            b         <= 1'b0;
            s         <= 1'b0;
            exe_cmd   <= '0;
        end else if (out_free) begin
            // A failed condition still retires, but with every side effect masked
            out_valid     <= 1'b1;
            wb_en         <= d_wb_en && cond_ok;
            mem_r_en      <= d_mem_r_en && cond_ok;
            mem_w_en      <= d_mem_w_en && cond_ok;
            b             <= d_b && cond_ok;
            s             <= d_s && cond_ok;
            imm           <= imm_bit;
            two_src       <= d_two_src;
            exe_cmd       <= d_exe_cmd;
            dest          <= d_dest;
            src1          <= d_src1;
            src2          <= d_src2;
            shift_operand <= instruction[11:0];
            signed_imm_24 <= instruction[23:0];
            val_rn        <= rn_value;
            val_rm        <= rm_value;
            pc_out        <= pc_in;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a spec-level model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  localparam logic [31:0] I_ADD    = 32'hE0813002;  // ADD R3,R1,R2
  localparam logic [31:0] I_ADD21  = 32'hE0823001;  // ADD R3,R2,R1
  localparam logic [31:0] I_ADDI   = 32'hE2813002;  // ADD R3,R1,#2
  localparam logic [31:0] I_SUB    = 32'hE0415002;  // SUB R5,R1,R2
  localparam logic [31:0] I_MOV    = 32'hE3A06003;  // MOV R6,#3
  localparam logic [31:0] I_ADDEQ  = 32'h00813002;
  localparam logic [31:0] I_STR    = 32'hE5814000;  // STR R4,[R1]
  localparam logic [31:0] I_LDR    = 32'hE5917000;  // LDR R7,[R1]
  localparam logic [31:0] I_B      = 32'hEA000010;
  localparam logic [31:0] I_UNDEF  = 32'hE0613002;
  localparam logic [31:0] I_NV     = 32'hF0813002;
  localparam logic [31:0] I_CMP    = 32'hE1510002;  // CMP R1,R2

  localparam logic [31:0] RND_INS [12] = '{I_ADD, I_ADD21, I_ADDI, I_SUB, I_MOV, I_ADDEQ,
                                           I_STR, I_LDR, I_B, I_UNDEF, I_NV, I_CMP};

  localparam logic [3:0] ALU_OP  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                                          4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
  localparam logic [3:0] ALU_CMD [11] = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5,
                                          4'd6, 4'd7, 4'd8, 4'd4, 4'd6};

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_in;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic [3:0]        sr;
  logic              wb_en_in;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              exe_wb_en;
  logic              mem_wb_en;
  logic [REG_W-1:0]  exe_dest;
  logic [REG_W-1:0]  mem_dest;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic              imm;
  logic              two_src;
  logic [3:0]        exe_cmd;
  logic [REG_W-1:0]  dest;
  logic [REG_W-1:0]  src1;
  logic [REG_W-1:0]  src2;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] pc_out;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  id_stage_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .sr(sr), .wb_en_in(wb_en_in),
    .wb_dest(wb_dest), .wb_value(wb_value), .exe_wb_en(exe_wb_en),
    .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .imm(imm), .two_src(two_src), .exe_cmd(exe_cmd), .dest(dest), .src1(src1),
    .src2(src2), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .val_rn(val_rn), .val_rm(val_rm), .pc_out(pc_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic        imm;
    logic        two_src;
    logic [3:0]  exe_cmd;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic        known;
    dec_t        d;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] pc;
  } mstate_t;

  logic [31:0] m_regs [16];
  mstate_t     ms;

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t d;
    logic is_store;
    d = '0;
    is_store = (ins[27:26] == 2'd1) && !ins[20];
    d.imm = ins[25];
    d.dest = ins[15:12];
    d.src1 = ins[19:16];
    d.src2 = is_store ? ins[15:12] : ins[3:0];
    d.two_src = !ins[25] || is_store;
    d.shift_operand = ins[11:0];
    d.signed_imm_24 = ins[23:0];
    if (ins[27:26] == 2'd0) begin
      for (int i = 0; i < 11; i++) begin
        if (ALU_OP[i] == ins[24:21]) begin
          d.exe_cmd = ALU_CMD[i];
          d.wb_en = (i < 9);
          d.s = ins[20];
        end
      end
    end else if (ins[27:26] == 2'd1) begin
      d.exe_cmd = 4'd2;
      d.mem_r_en = ins[20];
      d.wb_en = ins[20];
      d.mem_w_en = !ins[20];
    end else if (ins[27:26] == 2'd2) begin
      d.b = 1'b1;
    end
    return d;
  endfunction

  // Codes pair up: even code tests a predicate, the next odd code its inverse
  function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
    logic nf, zf, cf, vf, base;
    nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
    case (code[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf & ~zf;
      3'd5: base = (nf == vf);
      3'd6: base = ~zf & (nf == vf);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  function automatic logic model_busy(input logic [3:0] r);
    return (exe_wb_en && exe_dest == r) || (mem_wb_en && mem_dest == r);
  endfunction

  function automatic logic model_hazard(input logic [31:0] ins);
    dec_t d;
    d = model_decode(ins);
    if (!in_valid || ins[27:26] == 2'd2) return 1'b0;
    return model_busy(d.src1) || (d.two_src && model_busy(d.src2));
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] r);
`ifdef ID_STAGE_WB_BYPASS_EN
    if (wb_en_in && wb_dest == r) return wb_value;
`endif
    return m_regs[r];
  endfunction

  function automatic logic model_in_ready();
    if (!rst) return 1'b0;
    if (flush) return 1'b1;
    return !model_hazard(instruction) && (!ms.valid || out_ready);
  endfunction

  function automatic mstate_t model_bubble(input mstate_t cur);
    mstate_t nx;
    nx = cur;
    nx.valid = 1'b0;
    nx.known = 1'b0;
    nx.d.wb_en = 1'b0;
    nx.d.mem_r_en = 1'b0;
    nx.d.mem_w_en = 1'b0;
    nx.d.b = 1'b0;
    nx.d.s = 1'b0;
    nx.d.exe_cmd = 4'd0;
    return nx;
  endfunction

  function automatic mstate_t model_step(input mstate_t cur);
    mstate_t nx;
    dec_t d;
    nx = cur;
    if (!rst) begin
      nx = '0;
      nx.known = 1'b1;
    end else if (flush) begin
      nx = model_bubble(cur);
    end else if (cur.valid && !out_ready) begin
      nx = cur;
    end else if (model_hazard(instruction) || !in_valid) begin
      nx = model_bubble(cur);
    end else begin
      d = model_decode(instruction);
      if (!model_cond(instruction[31:28], sr)) begin
        d.wb_en = 1'b0;
        d.mem_r_en = 1'b0;
        d.mem_w_en = 1'b0;
        d.b = 1'b0;
        d.s = 1'b0;
      end
      nx.valid = 1'b1;
      nx.known = 1'b1;
      nx.d = d;
      nx.rn = model_read(d.src1);
      nx.rm = model_read(d.src2);
      nx.pc = pc_in;
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    ms <= model_step(ms);
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
    end else if (wb_en_in) begin
      m_regs[wb_dest] <= wb_value;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, model_in_ready());
      check("m_out_valid", out_valid, ms.valid);
      check("m_wb_en", wb_en, ms.d.wb_en);
      check("m_mem_r_en", mem_r_en, ms.d.mem_r_en);
      check("m_mem_w_en", mem_w_en, ms.d.mem_w_en);
      check("m_b", b, ms.d.b);
      check("m_s", s, ms.d.s);
      check("m_exe_cmd", exe_cmd, ms.d.exe_cmd);
      if (ms.known) begin
        check("m_imm", imm, ms.d.imm);
        check("m_two_src", two_src, ms.d.two_src);
        check("m_dest", dest, ms.d.dest);
        check("m_src1", src1, ms.d.src1);
        check("m_src2", src2, ms.d.src2);
        check("m_shift_operand", shift_operand, ms.d.shift_operand);
        check("m_signed_imm_24", signed_imm_24, ms.d.signed_imm_24);
        check("m_val_rn", val_rn, ms.rn);
        check("m_val_rm", val_rm, ms.rm);
        check("m_pc_out", pc_out, ms.pc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wb_en_in = 1'b0;
    exe_wb_en = 1'b0;
    mem_wb_en = 1'b0;
    sr = 4'b0000;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instruction = ins;
    pc_in = pc;
    in_valid = 1'b1;
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
    wb_en_in = 1'b1;
    wb_dest = r;
    wb_value = v;
    cycle();
    wb_en_in = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1; sr = 4'b0000;
    instruction = I_ADD; pc_in = 32'h0; wb_en_in = 1'b1; wb_dest = 4'd3;
    wb_value = 32'hDEAD; exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_dest = 4'd0; mem_dest = 4'd0;
    cycle();
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 1'b0);
    cycle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pc_out", pc_out, 32'h0);
    rst = 1'b1;
    set_idle();
    cycle();

    // register writes, then ADD R3,R1,R2
    write_reg(4'd1, 32'd5);
    write_reg(4'd2, 32'd7);
    issue(I_ADD, 32'h100);
    #1 check("add_in_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("add_out_valid", out_valid, 1'b1);
    check("add_exe_cmd", exe_cmd, 4'b0010);
    check("add_wb_en", wb_en, 1'b1);
    check("add_dest", dest, 4'd3);
    check("add_val_rn", val_rn, 32'd5);
    check("add_val_rm", val_rm, 32'd7);
    check("add_pc_out", pc_out, 32'h100);

    // execute-stage hazard on R1
    issue(I_ADD, 32'h104);
    exe_wb_en = 1'b1; exe_dest = 4'd1;
    #1 check("haz_in_ready", in_ready, 1'b0);
    cycle();
    check("haz_bubble", out_valid, 1'b0);
    exe_wb_en = 1'b0;
    #1 check("haz_clear_in_ready", in_ready, 1'b1);
    cycle();
    check("haz_issue_valid", out_valid, 1'b1);
    check("haz_issue_pc", pc_out, 32'h104);
    set_idle();
    cycle();

    // downstream backpressure for three cycles
    issue(I_SUB, 32'h200);
    out_ready = 1'b0;
    cycle();
    check("bp_load_valid", out_valid, 1'b1);
    issue(I_MOV, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready, 1'b0);
      cycle();
      check("bp_exe_cmd", exe_cmd, 4'b0100);
      check("bp_pc_out", pc_out, 32'h200);
      check("bp_val_rn", val_rn, 32'd5);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1'b1);
    cycle();
    check("mov_exe_cmd", exe_cmd, 4'b0001);
    check("mov_pc_out", pc_out, 32'h204);
    check("mov_imm", imm, 1'b1);
    check("mov_two_src", two_src, 1'b0);
    check("mov_shift_operand", shift_operand, 12'h003);

    // condition codes
    issue(I_ADDEQ, 32'h300);
    sr = 4'b0000;
    cycle();
    check("addeq_false_valid", out_valid, 1'b1);
    check("addeq_false_wb_en", wb_en, 1'b0);
    check("addeq_false_exe_cmd", exe_cmd, 4'b0010);
    issue(I_ADDEQ, 32'h304);
    sr = 4'b0100;
    cycle();
    check("addeq_true_wb_en", wb_en, 1'b1);
    sr = 4'b0000;

    // store uses rd as second source
    issue(I_STR, 32'h400);
    cycle();
    check("str_src2", src2, 4'd4);
    check("str_mem_w_en", mem_w_en, 1'b1);
    check("str_two_src", two_src, 1'b1);
    check("str_wb_en", wb_en, 1'b0);

    // flush drops a valid LDR, and overrides a stalled output
    issue(I_LDR, 32'h500);
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 1'b1);
    cycle();
    check("flush_bubble", out_valid, 1'b0);
    flush = 1'b0;
    issue(I_LDR, 32'h504);
    cycle();
    check("ldr_mem_r_en", mem_r_en, 1'b1);
    check("ldr_wb_en", wb_en, 1'b1);
    check("ldr_dest", dest, 4'd7);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    cycle();
    check("flush_stalled_bubble", out_valid, 1'b0);
    set_idle();

    // write-back in the same cycle as a read of R2
    issue(I_ADD21, 32'h600);
    wb_en_in = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
    cycle();
`ifdef ID_STAGE_WB_BYPASS_EN
    check("wbsame_val_rn", val_rn, 32'h55);
`else
    check("wbsame_val_rn", val_rn, 32'd7);
`endif
    check("wbsame_val_rm", val_rm, 32'd5);
    wb_en_in = 1'b0;
    issue(I_ADD21, 32'h604);
    cycle();
    check("wbnext_val_rn", val_rn, 32'h55);

    // branch ignores hazard sources
    issue(I_B, 32'h700);
    exe_wb_en = 1'b1; exe_dest = 4'd0; mem_wb_en = 1'b1; mem_dest = 4'd0;
    #1 check("b_in_ready", in_ready, 1'b1);
    cycle();
    check("b_b", b, 1'b1);
    check("b_wb_en", wb_en, 1'b0);
    check("b_signed_imm_24", signed_imm_24, 24'h000010);
    exe_wb_en = 1'b0; mem_wb_en = 1'b0;

    // undefined opcode and never-condition
    issue(I_UNDEF, 32'h710);
    cycle();
    check("undef_valid", out_valid, 1'b1);
    check("undef_exe_cmd", exe_cmd, 4'b0000);
    check("undef_wb_en", wb_en, 1'b0);
    issue(I_NV, 32'h714);
    cycle();
    check("nv_valid", out_valid, 1'b1);
    check("nv_wb_en", wb_en, 1'b0);

    // memory-stage hazard on src2 only counts for two-source forms
    issue(I_ADD, 32'h720);
    mem_wb_en = 1'b1; mem_dest = 4'd2;
    #1 check("memhaz_in_ready", in_ready, 1'b0);
    cycle();
    check("memhaz_bubble", out_valid, 1'b0);
    issue(I_ADDI, 32'h724);
    #1 check("memhaz_imm_in_ready", in_ready, 1'b1);
    cycle();
    check("memhaz_imm_valid", out_valid, 1'b1);
    mem_wb_en = 1'b0;

    // reset while stalled
    set_idle();
    cycle();
    issue(I_SUB, 32'h730);
    out_ready = 1'b0;
    cycle();
    check("rstall_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1 check("rstall_in_ready", in_ready, 1'b0);
    cycle();
    check("rstall_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    #1 check("rstall_release_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    issue(I_ADD, 32'h800);
    cycle();
    check("rstall_regs_cleared", val_rn, 32'd0);

    // mixed traffic, model-checked every cycle
    for (int i = 0; i < 60; i++) begin
      instruction = RND_INS[$urandom_range(0, 11)];
      pc_in = 32'h1000 + 32'(i * 4);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 7) == 0);
      sr = 4'($urandom_range(0, 15));
      exe_wb_en = ($urandom_range(0, 3) == 0);
      exe_dest = 4'($urandom_range(0, 7));
      mem_wb_en = ($urandom_range(0, 3) == 0);
      mem_dest = 4'($urandom_range(0, 7));
      wb_en_in = ($urandom_range(0, 1) == 1);
      wb_dest = 4'($urandom_range(0, 7));
      wb_value = $urandom;
      cycle();
    end

    set_idle();
    repeat (3) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
